// File: rtl/pipe_if_gen.sv
// pipe_if_gen: instruction-fetch stage with PC, private sync-read RAM and IF/ID register.
// Define IF_PERF_CNT_EN to add fetch/bubble performance counters.
module pipe_if_gen #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int PC_W = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_waddr,
    input  logic [DATA_W-1:0] imem_wdata,
    output logic [PC_W-1:0]   fetch_pc,
    output logic [DATA_W-1:0] if_instr,
    output logic [PC_W-1:0]   if_pc,
    output logic [PC_W-1:0]   if_pc4,
    output logic              if_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_bubble_cnt
`endif
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [PC_W-1:0] pc;
    logic [ADDR_W-1:0] idx;
    logic unused_ok;

    assign idx = pc[ADDR_W+1:2];
    assign fetch_pc = pc;
    assign unused_ok = ^redirect_pc[1:0];

    always_ff @(posedge clk)
        if (imem_we) mem[imem_waddr] <= imem_wdata;

    // The read only fires on normal edges, so a stalled IF/ID stays bit-stable.
    always_ff @(posedge clk)
        if (rst) begin
            pc <= RESET_PC;
            if_instr <= '0;
            if_pc <= '0;
            if_pc4 <= '0;
            if_valid <= 1'b0;
        end else if (redirect) begin
            pc <= {redirect_pc[PC_W-1:2], 2'b00};
            if_valid <= 1'b0;
        end else if (!stall) begin
            if_instr <= mem[idx];
            if_pc <= pc;
            if_pc4 <= pc + PC_W'(4);
            if_valid <= 1'b1;
            pc <= pc + PC_W'(4);
        end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk)
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_bubble_cnt <= '0;
        end else if (redirect || stall)
            perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
        else
            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
`endif
endmodule

// File: tb/tb_pipe_if_gen.sv
// tb_pipe_if_gen: randomized fetch-stage test against a behavioural reference model.
module tb_pipe_if_gen;
    localparam int DW = 32;
    localparam int AW = 3;
    localparam int PW = 8;
    localparam int DEPTH = 1 << AW;
    localparam logic [PW-1:0] RPC = 8'h04;

    logic clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect = 1'b0, imem_we = 1'b0;
    logic [PW-1:0] redirect_pc = '0;
    logic [AW-1:0] imem_waddr = '0;
    logic [DW-1:0] imem_wdata = '0;
    logic [PW-1:0] fetch_pc, if_pc, if_pc4;
    logic [DW-1:0] if_instr;
    logic if_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
`endif

    pipe_if_gen #(.DATA_W(DW), .ADDR_W(AW), .PC_W(PW), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .fetch_pc(fetch_pc), .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4),
        .if_valid(if_valid)
`ifdef IF_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic [DW-1:0] mm [DEPTH];
    logic [PW-1:0] m_pc, m_ipc, m_ipc4;
    logic [DW-1:0] m_instr;
    logic m_valid;
    int unsigned m_fet, m_bub;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge: advance the reference model from the sampled inputs, then compare.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_pc = RPC; m_instr = '0; m_ipc = '0; m_ipc4 = '0; m_valid = 1'b0;
            m_fet = 0; m_bub = 0;
        end else begin
            if (redirect || stall) m_bub++; else m_fet++;
            if (redirect) begin
                m_pc = redirect_pc - PW'(redirect_pc % 4);
                m_valid = 1'b0;
            end else if (!stall) begin
                m_instr = mm[(int'(m_pc) / 4) % DEPTH];
                m_ipc = m_pc;
                m_ipc4 = m_pc + PW'(4);
                m_valid = 1'b1;
                m_pc = m_pc + PW'(4);
            end
        end
        if (imem_we) mm[imem_waddr] = imem_wdata;
        #1;
        chk("fetch_pc", 64'(fetch_pc), 64'(m_pc));
        chk("if_instr", 64'(if_instr), 64'(m_instr));
        chk("if_pc", 64'(if_pc), 64'(m_ipc));
        chk("if_pc4", 64'(if_pc4), 64'(m_ipc4));
        chk("if_valid", 64'(if_valid), 64'(m_valid));
`ifdef IF_PERF_CNT_EN
        chk("perf_fetch", 64'(perf_fetch_cnt), 64'(m_fet));
        chk("perf_bubble", 64'(perf_bubble_cnt), 64'(m_bub));
`endif
    endtask

    task automatic drive(input logic r, input logic s, input logic rd, input logic [PW-1:0] rp,
                         input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        rst = r; stall = s; redirect = rd; redirect_pc = rp;
        imem_we = we; imem_waddr = wa; imem_wdata = wd;
        step();
    endtask

    initial begin
        // Preload every word while held in reset.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 1'b0, '0, 1'b1, AW'(i), DW'(32'h11111111 * (i + 1)));
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
        chk("first_fetch_pc", 64'(if_pc), 64'(RPC));
        chk("first_fetch_instr", 64'(if_instr), 64'h22222222);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, '0);
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
        drive(1'b0, 1'b1, 1'b1, 8'h0E, 1'b0, '0, '0);
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 3'd3, 32'hDEADBEEF);
        chk("read_first", 64'(if_instr), 64'h44444444);
        drive(1'b0, 1'b0, 1'b1, 8'h0C, 1'b0, '0, '0);
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
        chk("new_data", 64'(if_instr), 64'hDEADBEEF);
        for (int i = 0; i < 800; i++)
            drive($urandom_range(99) == 0, $urandom_range(3) == 0, $urandom_range(6) == 0,
                  PW'($urandom), $urandom_range(2) == 0, AW'($urandom), $urandom);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
